// File: rtl/intc_priority_if.sv
// CPU register-window bus for the priority interrupt controller.
// master = CPU side, slave = controller side.
interface intc_priority_if;
    logic        select;
    logic [3:0]  we;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output select, we, rd, addr, wdata,
        input  rdata
    );

    modport slave (
        input  select, we, rd, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/intc_priority.sv
// Fixed-priority nesting interrupt controller, source 0 highest.
// Edge/level sources, claim/EOI, registered irq_out.
module intc_priority #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             resetq,
    intc_priority_if.slave   bus,
    input  logic [N_SRC-1:0] irq_in,
    output logic             irq_out
);

    logic [N_SRC-1:0] s1, s2, s3;
    logic [N_SRC-1:0] enable, mode, pend_q, in_srv;
    logic [N_SRC-1:0] pend, edge_hit, elig;
    logic [N_SRC-1:0] w1c, claim_hit, eoi_hit;
    logic             wr_en, eoi_wr, claim_fire;
    logic             claim_valid;
    logic [2:0]       claim_id;
    logic             unused;

    assign unused = ^{bus.we[3:1], bus.wdata[31:N_SRC]};

    assign wr_en      = bus.select & bus.we[0];
    assign eoi_wr     = wr_en & (bus.addr == 2'd3);
    assign claim_fire = bus.select & bus.rd
                      & (bus.addr == 2'd3) & claim_valid;
    assign w1c        = (wr_en && bus.addr == 2'd2)
                      ? bus.wdata[N_SRC-1:0] : '0;

    // Level sources present the live synchronised input as pending.
    always_comb begin
        logic blocked;
        edge_hit    = s2 & ~s3;
        pend        = (mode & pend_q) | (~mode & s2);
        elig        = '0;
        claim_valid = 1'b0;
        claim_id    = 3'd0;
        blocked     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked = blocked | in_srv[i];
            elig[i] = pend[i] & enable[i] & ~blocked;
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                claim_valid = 1'b1;
                claim_id    = 3'(i);
            end
        end
    end

    always_comb begin
        claim_hit = '0;
        eoi_hit   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_hit[i] = claim_fire & (claim_id == 3'(i));
            eoi_hit[i]   = eoi_wr & (bus.wdata[2:0] == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            enable  <= '0;
            mode    <= '0;
            pend_q  <= '0;
            in_srv  <= '0;
            irq_out <= 1'b0;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
            if (wr_en && bus.addr == 2'd0)
                enable <= bus.wdata[N_SRC-1:0];
            if (wr_en && bus.addr == 2'd1)
                mode <= bus.wdata[N_SRC-1:0];
            // A new edge wins over W1C or claim in the same cycle.
            pend_q <= (mode & (edge_hit
                    | (pend_q & ~(w1c | claim_hit))))
                    | (~mode & s2);
            in_srv  <= (in_srv & ~eoi_hit) | claim_hit;
            irq_out <= |elig;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.select) begin
            unique case (bus.addr)
                2'd0: bus.rdata = {24'd0, 8'(enable)};
                2'd1: bus.rdata = {24'd0, 8'(mode)};
                2'd2: bus.rdata = {24'd0, 8'(pend)};
                2'd3: bus.rdata = {claim_valid, 28'd0, claim_id};
                default: bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_priority.sv
// Scoreboard bench for intc_priority: expectations are queued
// with each stimulus and popped when the DUT output is sampled.
module tb_intc_priority;

    logic       clk = 1'b0;
    logic       resetq = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       irq_out;

    intc_priority_if bus_if ();

    intc_priority #(.N_SRC(8)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus_if),
        .irq_in (irq_in),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h want=%h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.select = 1'b1;
        bus_if.we     = 4'h1;
        bus_if.addr   = a;
        bus_if.wdata  = d;
        step(1);
        bus_if.select = 1'b0;
        bus_if.we     = 4'h0;
    endtask

    task automatic peek(input logic [1:0] a, input logic [31:0] exp,
                        input string tag);
        sb_q.push_back(exp);
        bus_if.select = 1'b1;
        bus_if.addr   = a;
        #1;
        chk(tag, bus_if.rdata, sb_q.pop_front());
        bus_if.select = 1'b0;
    endtask

    task automatic claim_rd(input logic [31:0] exp, input string tag);
        sb_q.push_back(exp);
        bus_if.select = 1'b1;
        bus_if.rd     = 1'b1;
        bus_if.addr   = 2'd3;
        #1;
        chk(tag, bus_if.rdata, sb_q.pop_front());
        step(1);
        bus_if.select = 1'b0;
        bus_if.rd     = 1'b0;
    endtask

    task automatic see_irq(input logic exp, input string tag);
        sb_q.push_back({31'd0, exp});
        chk(tag, {31'd0, irq_out}, sb_q.pop_front());
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = irq_in | m;
        step(1);
        irq_in = irq_in & ~m;
    endtask

    initial begin
        bus_if.select = 1'b0;
        bus_if.we     = 4'h0;
        bus_if.rd     = 1'b0;
        bus_if.addr   = 2'd0;
        bus_if.wdata  = '0;
        irq_in        = 8'h01;
        step(2);
        peek(2'd0, 32'h0, "rst_en");
        peek(2'd1, 32'h0, "rst_mode");
        peek(2'd2, 32'h0, "rst_pend");
        peek(2'd3, 32'h0, "rst_claim");
        see_irq(1'b0, "rst_irq");
        bus_if.addr = 2'd0;
        #1;
        chk("rdata_desel", bus_if.rdata, 32'h0);
        resetq = 1'b1;

        // input high through reset release: exactly one edge event
        wr(2'd1, 32'h01);
        step(3);
        peek(2'd2, 32'h01, "rel_pend");
        wr(2'd2, 32'h01);
        step(4);
        peek(2'd2, 32'h00, "rel_once");
        irq_in = 8'h00;
        step(3);

        // edge latency
        wr(2'd0, 32'h01);
        pulse(8'h01);
        step(2);
        see_irq(1'b0, "lat_e3");
        step(1);
        see_irq(1'b1, "lat_e4");
        claim_rd(32'h8000_0000, "lat_claim");
        peek(2'd2, 32'h00, "lat_pend");
        step(1);
        see_irq(1'b0, "lat_irq_off");
        wr(2'd3, 32'h0);

        // priority and nesting
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        pulse(8'h24);
        step(3);
        see_irq(1'b1, "nest_irq");
        claim_rd(32'h8000_0002, "nest_c2");
        step(1);
        see_irq(1'b0, "nest_fall");
        pulse(8'h01);
        step(3);
        see_irq(1'b1, "nest_pre");
        claim_rd(32'h8000_0000, "nest_c0");
        pulse(8'h08);
        step(3);
        see_irq(1'b0, "nest_mask3");
        claim_rd(32'h0, "nest_none");
        wr(2'd3, 32'h0);
        claim_rd(32'h0, "nest_still");
        wr(2'd3, 32'h2);
        claim_rd(32'h8000_0003, "nest_c3");
        wr(2'd3, 32'h3);
        claim_rd(32'h8000_0005, "nest_c5");
        wr(2'd3, 32'h5);

        // level source
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h10);
        irq_in = 8'h10;
        step(2);
        see_irq(1'b0, "lvl_e2");
        step(1);
        see_irq(1'b1, "lvl_e3");
        claim_rd(32'h8000_0004, "lvl_claim");
        peek(2'd2, 32'h10, "lvl_pend");
        wr(2'd3, 32'h4);
        step(1);
        see_irq(1'b1, "lvl_eoi");
        irq_in = 8'h00;
        step(1);
        peek(2'd2, 32'h10, "lvl_d1");
        step(1);
        peek(2'd2, 32'h00, "lvl_d2");
        see_irq(1'b1, "lvl_irq2");
        step(1);
        see_irq(1'b0, "lvl_irq3");

        // W1C colliding with a new edge
        wr(2'd0, 32'h00);
        wr(2'd1, 32'hFF);
        pulse(8'h02);
        step(3);
        peek(2'd2, 32'h02, "col_set");
        irq_in = 8'h02;
        step(1);
        irq_in = 8'h00;
        step(1);
        wr(2'd2, 32'h02);
        peek(2'd2, 32'h02, "col_win");
        wr(2'd2, 32'h02);
        peek(2'd2, 32'h00, "col_clr");

        // stray EOI, then reset mid-service
        wr(2'd0, 32'hFF);
        pulse(8'h08);
        step(3);
        claim_rd(32'h8000_0003, "svc_c3");
        wr(2'd3, 32'h7);
        pulse(8'h20);
        step(3);
        see_irq(1'b0, "eoi7_mask");
        claim_rd(32'h0, "eoi7_none");
        resetq = 1'b0;
        #1;
        see_irq(1'b0, "mid_irq");
        peek(2'd0, 32'h0, "mid_en");
        peek(2'd1, 32'h0, "mid_mode");
        peek(2'd2, 32'h0, "mid_pend");
        peek(2'd3, 32'h0, "mid_claim");
        resetq = 1'b1;
        step(1);
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        pulse(8'h20);
        step(3);
        see_irq(1'b1, "post_irq");
        claim_rd(32'h8000_0005, "post_c5");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
